// File: rtl/apb_wb_bridge_pkg.sv
// Shared definitions for the APB4-to-Wishbone bridge: bus widths, FSM states
// and the sizing helper for the response timeout counter.
package bus_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;
  localparam int WB_DATA_W  = 32;
  localparam int WB_SEL_W   = WB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter must hold values up to TIMEOUT and never be narrower than one bit.
  function automatic int cntWidth(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_wb_bridge_if.sv
// Bundles the APB slave side and the Wishbone master side of the bridge.
// The slave modport is the bridge's view; master is the surrounding system.
interface apb_wb_bridge_if #(
  parameter int ADDR_WIDTH = 16
);
  import bus_pkg::*;

  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [APB_DATA_W-1:0] pwdata_i;
  logic [APB_STRB_W-1:0] pstrb_i;
  logic                  pready_o;
  logic [APB_DATA_W-1:0] prdata_o;
  logic                  pslverr_o;

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [WB_SEL_W-1:0]   wb_sel_o;
  logic                  wb_we_o;
  logic [WB_DATA_W-1:0]  wb_dat_o;
  logic                  wb_stall_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic [WB_DATA_W-1:0]  wb_dat_i;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o,
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
    input  wb_stall_i, wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o,
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
    output wb_stall_i, wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
  );

endinterface

// File: rtl/apb_wb_bridge.sv
// APB4 slave to pipelined Wishbone B4 master: one single-beat WB cycle per APB
// access, with every output registered to isolate the APB fabric timing.
module apb_wb_bridge
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  apb_wb_bridge_if.slave bus
);

  localparam int              CNT_W    = cntWidth(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_setup;
  logic                  w_resp;
  logic                  w_timeout;
  logic                  w_finish;
  logic                  w_fail;
  logic                  w_loadRd;
  logic [DATA_WIDTH-1:0] w_rdData;

  assign w_setup   = bus.psel_i && !bus.penable_i;
  assign w_resp    = bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_rdData  = bus.wb_dat_i;
  assign w_loadRd  = w_finish && !w_fail && !bus.wb_we_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A real response beats a simultaneous timeout; err and rty both map to pslverr.
  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
    w_fail   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_next = REQ;
        end
      end
      REQ: begin
        if (!bus.wb_stall_i && w_resp) begin
          w_finish = 1'b1;
          w_fail   = bus.wb_err_i || bus.wb_rty_i;
        end else if (w_timeout) begin
          w_finish = 1'b1;
          w_fail   = 1'b1;
        end else if (!bus.wb_stall_i) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (w_resp) begin
          w_finish = 1'b1;
          w_fail   = bus.wb_err_i || bus.wb_rty_i;
        end else if (w_timeout) begin
          w_finish = 1'b1;
          w_fail   = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (w_finish) begin
      w_next = DONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.pready_o  <= 1'b0;
      bus.pslverr_o <= 1'b0;
      bus.prdata_o  <= '0;
      bus.wb_cyc_o  <= 1'b0;
      bus.wb_stb_o  <= 1'b0;
      bus.wb_adr_o  <= '0;
      bus.wb_sel_o  <= '0;
      bus.wb_we_o   <= 1'b0;
      bus.wb_dat_o  <= '0;
      r_cnt         <= '0;
    end else begin
      bus.pready_o <= w_finish;
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            bus.wb_adr_o <= bus.paddr_i;
            bus.wb_we_o  <= bus.pwrite_i;
            bus.wb_dat_o <= bus.pwdata_i;
            bus.wb_sel_o <= bus.pwrite_i ? bus.pstrb_i : 4'hF;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            r_cnt        <= '0;
          end
        end
        REQ, WAIT: begin
          if (w_finish) begin
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            bus.pslverr_o <= w_fail;
            bus.prdata_o  <= w_loadRd ? w_rdData : '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_next == WAIT) begin
              bus.wb_stb_o <= 1'b0;
            end
          end
        end
        DONE: begin
          bus.pslverr_o <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_wb_bridge.sv
// Directed bench for apb_wb_bridge with TIMEOUT=8: writes, stalled reads,
// error and timeout responses, back-to-back traffic and reset mid-transfer.
module tb_apb_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          nCompared = 0;
  int          nFailed = 0;
  int          nCyc;
  logic [31:0] regFile [4];

  apb_wb_bridge_if #(.ADDR_WIDTH(16)) bus ();

  apb_wb_bridge #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .TIMEOUT   (8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    nFailed++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic psel, input logic penable, input logic pwrite,
                               input logic [15:0] paddr, input logic [31:0] pwdata,
                               input logic [3:0] pstrb);
    bus.psel_i    = psel;
    bus.penable_i = penable;
    bus.pwrite_i  = pwrite;
    bus.paddr_i   = paddr;
    bus.pwdata_i  = pwdata;
    bus.pstrb_i   = pstrb;
  endtask

  task automatic wbDrive(input logic stall, input logic ack, input logic err,
                         input logic rty, input logic [31:0] dat);
    bus.wb_stall_i = stall;
    bus.wb_ack_i   = ack;
    bus.wb_err_i   = err;
    bus.wb_rty_i   = rty;
    bus.wb_dat_i   = dat;
  endtask

  // Register-file slave: acks the current request, storing or returning a word.
  task automatic slaveAck();
    bus.wb_ack_i = 1'b1;
    if (bus.wb_we_o) regFile[bus.wb_adr_o[3:2]] = bus.wb_dat_o;
    else             bus.wb_dat_i = regFile[bus.wb_adr_o[3:2]];
  endtask

  initial begin
    for (int i = 0; i < 4; i++) regFile[i] = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("rst_cyc",     32'(bus.wb_cyc_o),  32'h0);
    checkOutput("rst_stb",     32'(bus.wb_stb_o),  32'h0);
    checkOutput("rst_adr",     32'(bus.wb_adr_o),  32'h0);
    checkOutput("rst_dat",     bus.wb_dat_o,       32'h0);
    checkOutput("rst_sel",     32'(bus.wb_sel_o),  32'h0);
    checkOutput("rst_pready",  32'(bus.pready_o),  32'h0);
    checkOutput("rst_prdata",  bus.prdata_o,       32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] write 0x15 to 0x0");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 32'h15, 4'hF);
    tick();
    checkOutput("t1_cyc", 32'(bus.wb_cyc_o), 32'h1);
    checkOutput("t1_stb", 32'(bus.wb_stb_o), 32'h1);
    checkOutput("t1_we",  32'(bus.wb_we_o),  32'h1);
    checkOutput("t1_sel", 32'(bus.wb_sel_o), 32'hF);
    checkOutput("t1_dat", bus.wb_dat_o,      32'h15);
    checkOutput("t1_adr", 32'(bus.wb_adr_o), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0, 32'h15, 4'hF);
    tick();
    checkOutput("t1_wait_stb",    32'(bus.wb_stb_o), 32'h0);
    checkOutput("t1_wait_cyc",    32'(bus.wb_cyc_o), 32'h1);
    checkOutput("t1_wait_pready", 32'(bus.pready_o), 32'h0);
    slaveAck();
    tick();
    checkOutput("t1_pready",  32'(bus.pready_o),  32'h1);
    checkOutput("t1_pslverr", 32'(bus.pslverr_o), 32'h0);
    checkOutput("t1_done_cyc", 32'(bus.wb_cyc_o), 32'h0);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    checkOutput("t1_idle_pready", 32'(bus.pready_o), 32'h0);
    tick();

    $display("[TB] read 0x4 with two stall cycles");
    regFile[1] = 32'h5;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h4, 32'h0, 4'h0);
    wbDrive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("t2_stb0", 32'(bus.wb_stb_o), 32'h1);
    checkOutput("t2_adr",  32'(bus.wb_adr_o), 32'h4);
    checkOutput("t2_sel",  32'(bus.wb_sel_o), 32'hF);
    checkOutput("t2_we",   32'(bus.wb_we_o),  32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4, 32'h0, 4'h0);
    tick();
    checkOutput("t2_stb1", 32'(bus.wb_stb_o), 32'h1);
    tick();
    checkOutput("t2_stb2",     32'(bus.wb_stb_o), 32'h1);
    checkOutput("t2_adr_hold", 32'(bus.wb_adr_o), 32'h4);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("t2_wait_stb", 32'(bus.wb_stb_o), 32'h0);
    checkOutput("t2_wait_cyc", 32'(bus.wb_cyc_o), 32'h1);
    slaveAck();
    tick();
    checkOutput("t2_pready",  32'(bus.pready_o),  32'h1);
    checkOutput("t2_prdata",  bus.prdata_o,       32'h5);
    checkOutput("t2_pslverr", 32'(bus.pslverr_o), 32'h0);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    checkOutput("t2_prdata_hold", bus.prdata_o,      32'h5);
    checkOutput("t2_idle_pready", 32'(bus.pready_o), 32'h0);
    tick();

    $display("[TB] error response on write to 0x8");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h8, 32'hDEADBEEF, 4'h3);
    tick();
    checkOutput("t3_sel", 32'(bus.wb_sel_o), 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h8, 32'hDEADBEEF, 4'h3);
    tick();
    wbDrive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("t3_pready",  32'(bus.pready_o),  32'h1);
    checkOutput("t3_pslverr", 32'(bus.pslverr_o), 32'h1);
    checkOutput("t3_prdata",  bus.prdata_o,       32'h0);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    checkOutput("t3_idle_pslverr", 32'(bus.pslverr_o), 32'h0);
    checkOutput("t3_idle_pready",  32'(bus.pready_o),  32'h0);
    tick();

    $display("[TB] no response, timeout after 8 cycles");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hC, 32'h1, 4'hF);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hC, 32'h1, 4'hF);
    nCyc = 0;
    while (bus.wb_cyc_o && nCyc < 20) begin
      nCyc++;
      tick();
    end
    checkOutput("t4_cyc_cycles", 32'(nCyc),           32'd8);
    checkOutput("t4_pready",     32'(bus.pready_o),  32'h1);
    checkOutput("t4_pslverr",    32'(bus.pslverr_o), 32'h1);
    checkOutput("t4_stb",        32'(bus.wb_stb_o),  32'h0);
    wbDrive(1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA5555);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    checkOutput("t4_late_pready",  32'(bus.pready_o),  32'h0);
    checkOutput("t4_late_pslverr", 32'(bus.pslverr_o), 32'h0);
    tick();
    checkOutput("t4_late_cyc",     32'(bus.wb_cyc_o),  32'h0);
    checkOutput("t4_late_pready2", 32'(bus.pready_o),  32'h0);
    checkOutput("t4_late_prdata",  bus.prdata_o,       32'h0);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("[TB] back-to-back write 0x7 then read of 0x0");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 32'h7, 4'hF);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0, 32'h7, 4'hF);
    tick();
    slaveAck();
    tick();
    checkOutput("t5_wr_pready",  32'(bus.pready_o),  32'h1);
    checkOutput("t5_wr_pslverr", 32'(bus.pslverr_o), 32'h0);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t5_rd_stb", 32'(bus.wb_stb_o), 32'h1);
    checkOutput("t5_rd_we",  32'(bus.wb_we_o),  32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    slaveAck();
    tick();
    checkOutput("t5_rd_pready", 32'(bus.pready_o), 32'h1);
    checkOutput("t5_rd_prdata", bus.prdata_o,      32'h7);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();

    $display("[TB] reset asserted during WAIT");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t6_wait_cyc", 32'(bus.wb_cyc_o), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_cyc",    32'(bus.wb_cyc_o), 32'h0);
    checkOutput("t6_rst_pready", 32'(bus.pready_o), 32'h0);
    checkOutput("t6_rst_prdata", bus.prdata_o,      32'h0);
    tick();
    checkOutput("t6_rst_pready2", 32'(bus.pready_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t6_post_pready", 32'(bus.pready_o), 32'h0);
    checkOutput("t6_post_cyc",    32'(bus.wb_cyc_o), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t6_new_cyc", 32'(bus.wb_cyc_o), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    slaveAck();
    tick();
    checkOutput("t6_new_pready",  32'(bus.pready_o),  32'h1);
    checkOutput("t6_new_prdata",  bus.prdata_o,       32'h7);
    checkOutput("t6_new_pslverr", 32'(bus.pslverr_o), 32'h0);
    wbDrive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
